// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (Moore). Sequences fetch, decode, execute,
// memory and writeback steps and drives all datapath selects/enables.
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   bad_opcode;
  logic   illegal_q;
  logic   pc_write;
  logic   branch;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (bad_opcode) illegal_q <= 1'b1;
    end
  end

  // Next-state selection; opcode is consulted in DECODE and again in MEMADR
  always_comb begin
    nxt_state  = FETCH;
    bad_opcode = 1'b0;
    case (cur_state)
      FETCH:  nxt_state = DECODE;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) nxt_state = MEMADR;
        else if (opcode == OP_RTYPE)            nxt_state = EXEC;
        else if (opcode == OP_BEQ)              nxt_state = BRANCH;
        else if (opcode == OP_ADDI)             nxt_state = ADDIEX;
        else if (opcode == OP_J)                nxt_state = JUMP;
        else begin
          nxt_state  = FETCH;
          bad_opcode = 1'b1;
        end
      end
      MEMADR: nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt_state = MEMWB;
      EXEC:   nxt_state = ALUWB;
      ADDIEX: nxt_state = ADDIWB;
      default: nxt_state = FETCH;
    endcase
  end

  // Moore output decode; anything not set for a state stays 0
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    case (cur_state)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: i_or_d = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch outcome is the only combinational path from an input to an output
  assign pc_en      = pc_write | (branch & alu_zero);
  assign illegal_op = illegal_q;
  assign state      = cur_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench for mips_multicycle_control against an
// instruction-level reference model (per-opcode step lists, per-step outputs).
module tb_mips_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  mips_multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clock = ~clock;

  logic [14:0] out_vec;
  assign out_vec = {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    else
      n_pass++;
  endtask

  // Reference model: step list for one instruction and the sticky flag
  int exp_seq[$];
  bit plan_illegal;
  bit model_illegal;

  function void plan(input logic [5:0] op);
    exp_seq.delete();
    plan_illegal = 1'b0;
    exp_seq.push_back(0);
    exp_seq.push_back(1);
    case (op)
      6'h23: begin exp_seq.push_back(2); exp_seq.push_back(3); exp_seq.push_back(4); end
      6'h2B: begin exp_seq.push_back(2); exp_seq.push_back(5); end
      6'h00: begin exp_seq.push_back(6); exp_seq.push_back(7); end
      6'h04: exp_seq.push_back(8);
      6'h08: begin exp_seq.push_back(9); exp_seq.push_back(10); end
      6'h02: exp_seq.push_back(11);
      default: plan_illegal = 1'b1;
    endcase
  endfunction

  // Expected control word for a step (field order matches out_vec)
  function automatic logic [14:0] exp_out(input int s, input logic z);
    logic pe, irw, iod, mw, rw, rd, m2r, sa, done;
    logic [1:0] sb, op, ps;
    {pe, irw, iod, mw, rw, rd, m2r, sa, done} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      0:  begin irw = 1; sb = 2'b01; pe = 1; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin m2r = 1; rw = 1; done = 1; end
      5:  begin iod = 1; mw = 1; done = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; rw = 1; done = 1; end
      8:  begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; done = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin ps = 2'b10; pe = 1; done = 1; end
      default: ;
    endcase
    return {pe, irw, iod, mw, rw, rd, m2r, sa, sb, op, ps, done};
  endfunction

  task automatic check_step(input int s);
    check("state", state, s);
    check("outputs", out_vec, exp_out(s, alu_zero));
    check("illegal_op", illegal_op, model_illegal);
    check("wr_excl", mem_write & reg_write, 0);
  endtask

  // Called one time unit after the edge that entered FETCH; returns likewise
  task automatic run_instr(input logic [5:0] op, input int zmode);
    plan(op);
    opcode = op;
    foreach (exp_seq[k]) begin
      alu_zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      @(negedge clock);
      check_step(exp_seq[k]);
      @(posedge clock); #1;
      if (exp_seq[k] == 1 && plan_illegal) model_illegal = 1'b1;
    end
  endtask

  logic [5:0] legal_ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};

  initial begin
    model_illegal = 1'b0;
    reset    = 1'b1;
    opcode   = 6'h23;
    alu_zero = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Directed sequences
    run_instr(6'h23, 0);
    run_instr(6'h2B, 0);
    run_instr(6'h00, 0);
    run_instr(6'h04, 1);
    run_instr(6'h04, 0);
    run_instr(6'h3F, 2);
    run_instr(6'h02, 2);
    check("illegal_sticky", illegal_op, 1);

    // Reset while in MEMRD of a load
    plan(6'h23);
    opcode = 6'h23;
    for (int k = 0; k < 4; k++) begin
      alu_zero = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_step(exp_seq[k]);
      if (k == 3) reset = 1'b1;
      @(posedge clock); #1;
    end
    reset = 1'b0;
    model_illegal = 1'b0;
    @(negedge clock);
    check_step(0);
    check("rst_no_regwrite", reg_write, 0);
    @(posedge clock); #1;
    // DECODE after the post-reset FETCH
    @(negedge clock);
    check("post_rst_decode", state, 1);
    check("post_rst_illegal", illegal_op, 0);
    @(posedge clock); #1;
    // Finish the instruction this DECODE selected, then resume normally
    plan(6'h23);
    for (int k = 2; k < 5; k++) begin
      @(negedge clock);
      check_step(exp_seq[k]);
      @(posedge clock); #1;
    end

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Moore-style control FSM for the multicycle MIPS datapath that follows the single-cycle LW implementation.
- Takes the opcode of the latched instruction register and the ALU zero flag.
- Sequences FETCH/DECODE/execute/memory/writeback steps.
- Drives every datapath mux select and enable, so one shared ALU and one unified memory serve the whole instruction.
- Sits beside the datapath and is instantiated inside the cpu top, which keeps its clock/reset ports.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction[31:26] from instruction register
alu_zero  in  1  ALU zero flag
pc_en  out  1  PC load enable = pc_write | (branch & alu_zero)
ir_write  out  1  latch memory read data into instruction register
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  unified memory write enable
reg_write  out  1  register file write enable
reg_dst  out  1  write register select: 0=rt, 1=rd
mem_to_reg  out  1  write data select: 0=ALUOut, 1=MDR
alu_src_a  out  1  ALU A select: 0=PC, 1=register A
alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse in the last state of each instruction
illegal_op  out  1  sticky flag, set on an undefined opcode in DECODE
state  out  4  current state encoding, exposed for debug

Behaviour:
- Single clock domain. reset is synchronous and active-high: it is sampled only at the rising clock edge.
- At a reset edge: state <= FETCH (0), illegal_op <= 0. Reset has priority over any transition, including mid-instruction. No writes may occur in the cycle after reset.
- State encoding is fixed:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - 12–15 are unused and return to FETCH on the next edge.
- Outputs are pure decode of state (Moore), except pc_en, which combines alu_zero combinationally. Every output not listed for a state is 0.
- Post-reset output values are the FETCH values below.
- Per-state outputs:
  - FETCH: i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed). Next by opcode:
    - LW or SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other opcode -> FETCH, and illegal_op <= 1 (stays set until reset).
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if opcode==LW, else MEMWR.
  - MEMRD: i_or_d=1. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWR: i_or_d=1, mem_write=1, instr_done=1. Next: FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1. pc_en follows alu_zero in the same cycle. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
  - JUMP: pc_src=10, pc_write=1, instr_done=1. Next: FETCH.
- opcode is assumed stable from DECODE onward. The FSM re-reads it in MEMADR to choose MEMRD vs MEMWR.
- Cycle counts, FETCH through last state inclusive:
  - LW = 5
  - SW, R-type, ADDI = 4
  - BEQ, J = 3
  - illegal opcode = 2 (no instr_done)
- mem_write and reg_write are never both 1 in the same cycle.

Test Plan:
- Reset held 2 cycles with opcode=6'h23, then released -> state=0 for the first post-reset cycle; ir_write=1, pc_en=1, alu_src_b=01, reg_write=0, mem_write=0, illegal_op=0.
- opcode=6'h23 (LW) -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once; total 5 cycles.
- opcode=6'h2B (SW) then 6'h00 (R-type) -> SW: 0,1,2,5 with mem_write=1 only in state 5. R-type: 0,1,6,7 with alu_op=10 in state 6 and reg_dst=1, reg_write=1 in state 7.
- opcode=6'h04 (BEQ) with alu_zero=1, then again with alu_zero=0 -> in state 8, pc_en=1 and pc_src=01 for the first; pc_en=0 for the second; each returns to state 0 after 3 cycles.
- opcode=6'h3F (illegal) -> 0,1,0; illegal_op=1 from the cycle after DECODE and still 1 after a following J (0,1,11,0, pc_src=10); cleared only by reset.
- Reset asserted while in state 3 during LW -> next state 0, reg_write never asserted, illegal_op=0.
